segment_scan_capture: RTL

- Receiving end of the multiplexed 7-segment display interface driven by the clock top level.
- Samples the segment lines and the 4-bit digit-select lines, waits for each digit to settle, and decodes each glyph back to a 4-bit value.
- Assembles the 4 digits into a frame and presents it through a valid/ready handshake.
- Used in the verification harness and as an on-chip loopback monitor for the display path.

---
 rtl/segment_scan_capture.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/segment_scan_capture.sv
// segment_scan_capture
//   Receiving end of a multiplexed 7-segment display bus. Each digit is
//   captured after its select/segment sample has been stable for
//   STABLE_CYCLES synchronized cycles. The glyph is decoded to a 4-bit code,
//   four digits are assembled into a frame, and the frame is presented on a
//   valid/ready handshake.
//
// Ports
//   clock        system clock, rising edge
//   reset        asynchronous active-high reset
//   segment[6:0] segment lines, bit0=a .. bit6=g
//   colon        colon / decimal-point line
//   digit_sel    digit enables, bit3 = leftmost digit
//   frame_data   digit3 in [15:12] .. digit0 in [3:0]
//   frame_colon  colon seen on any captured digit of the frame
//   frame_error  some digit of the frame decoded as invalid
//   frame_valid  frame available
//   frame_ready  consumer accepts on frame_valid && frame_ready
//   overrun      sticky: a completed frame was dropped while one was held
//   sel_error    sticky: a stable digit_sel had more than one bit set
//   display_off  digit_sel has been zero for TIMEOUT_CYCLES cycles
module segment_scan_capture #(
   parameter int unsigned STABLE_CYCLES  = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [6:0]  segment,
   input  logic        colon,
   input  logic [3:0]  digit_sel,
   output logic [15:0] frame_data,
   output logic        frame_colon,
   output logic        frame_error,
   output logic        frame_valid,
   input  logic        frame_ready,
   output logic        overrun,
   output logic        sel_error,
   output logic        display_off
);

   localparam logic [7:0]  STABLE_L  = 8'(STABLE_CYCLES);
   localparam logic [15:0] TIMEOUT_L = 16'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {WAIT_SEL, SETTLING, CAPTURE, LOCKED} state_t;

   // With STABLE_CYCLES == 1 the first non-zero sample is already stable.
   localparam state_t FIRST_ST = (STABLE_CYCLES <= 1) ? CAPTURE : SETTLING;

   // Returns {invalid, code}.
   function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
      logic [4:0] r;
      case (seg)
         7'h3F:   r = 5'h00;
         7'h06:   r = 5'h01;
         7'h5B:   r = 5'h02;
         7'h4F:   r = 5'h03;
         7'h66:   r = 5'h04;
         7'h6D:   r = 5'h05;
         7'h7D:   r = 5'h06;
         7'h07:   r = 5'h07;
         7'h7F:   r = 5'h08;
         7'h6F:   r = 5'h09;
         7'h00:   r = 5'h0F;
         default: r = 5'h1E;
      endcase
      return r;
   endfunction

   // Display-side synchronizer. frame_ready comes from a consumer in this
   // clock domain and is used directly so the handshake stays cycle-exact.
   logic [6:0]  seg_m_q, seg_s_q;
   logic [3:0]  sel_m_q, sel_s_q;
   logic        col_m_q, col_s_q;

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [3:0]  rec_sel_q, rec_sel_d;
   logic [6:0]  rec_seg_q, rec_seg_d;
   logic [3:0]  mask_q, mask_d;
   logic [15:0] pend_q, pend_d;
   logic        pcol_q, pcol_d, perr_q, perr_d;
   logic [15:0] data_q, data_d;
   logic        fcol_q, fcol_d, ferr_q, ferr_d, fvld_q, fvld_d;
   logic        ovr_q, ovr_d, selerr_q, selerr_d;
   logic [15:0] to_q, to_d;
   logic        off_q, off_d;

   logic [4:0]  glyph;
   logic        same;
   logic        onehot;
   logic [7:0]  cnt_inc;

   assign glyph   = decode_glyph(rec_seg_q);
   assign same    = (sel_s_q == rec_sel_q) && (seg_s_q == rec_seg_q);
   assign onehot  = (rec_sel_q != 4'd0) && ((rec_sel_q & (rec_sel_q - 4'd1)) == 4'd0);
   // cnt_q < STABLE_L <= 255 while settling, so this cannot wrap.
   assign cnt_inc = cnt_q + 8'd1;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rec_sel_d = rec_sel_q;
      rec_seg_d = rec_seg_q;
      mask_d    = mask_q;
      pend_d    = pend_q;
      pcol_d    = pcol_q;
      perr_d    = perr_q;
      data_d    = data_q;
      fcol_d    = fcol_q;
      ferr_d    = ferr_q;
      fvld_d    = fvld_q & ~frame_ready;
      ovr_d     = ovr_q;
      selerr_d  = selerr_q;
      to_d      = to_q;
      off_d     = off_q;

      case (state_q)
         WAIT_SEL: begin
            if (sel_s_q != 4'd0) begin
               cnt_d     = 8'd1;
               rec_sel_d = sel_s_q;
               rec_seg_d = seg_s_q;
               state_d   = FIRST_ST;
            end
         end
         SETTLING: begin
            if (same) begin
               if (cnt_inc >= STABLE_L) begin
                  cnt_d   = STABLE_L;
                  state_d = CAPTURE;
               end else begin
                  cnt_d = cnt_inc;
               end
            end else if (sel_s_q != 4'd0) begin
               cnt_d     = 8'd1;
               rec_sel_d = sel_s_q;
               rec_seg_d = seg_s_q;
            end else begin
               state_d = WAIT_SEL;
            end
         end
         CAPTURE: begin
            if (onehot) begin
               for (int i = 0; i < 4; i++) begin
                  if (rec_sel_q[i]) pend_d[4*i +: 4] = glyph[3:0];
               end
               mask_d = mask_q | rec_sel_q;
               pcol_d = pcol_q | col_s_q;
               perr_d = perr_q | glyph[4];
            end else begin
               selerr_d = 1'b1;
            end
            state_d = LOCKED;
         end
         default: begin // LOCKED
            if (!same) begin
               if (sel_s_q != 4'd0) begin
                  cnt_d     = 8'd1;
                  rec_sel_d = sel_s_q;
                  rec_seg_d = seg_s_q;
                  state_d   = FIRST_ST;
               end else begin
                  state_d = WAIT_SEL;
               end
            end
         end
      endcase

      // Frame completion; an acceptance in this same cycle frees the slot.
      if (mask_d == 4'hF) begin
         if (!fvld_q || frame_ready) begin
            data_d = pend_d;
            fcol_d = pcol_d;
            ferr_d = perr_d;
            fvld_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
         mask_d = 4'd0;
         pcol_d = 1'b0;
         perr_d = 1'b0;
      end

      if (sel_s_q == 4'd0) begin
         if (to_q < TIMEOUT_L) to_d = to_q + 16'd1;
         off_d = (to_d >= TIMEOUT_L);
      end else begin
         to_d  = 16'd0;
         off_d = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         seg_m_q   <= '0;
         seg_s_q   <= '0;
         sel_m_q   <= '0;
         sel_s_q   <= '0;
         col_m_q   <= 1'b0;
         col_s_q   <= 1'b0;
         state_q   <= WAIT_SEL;
         cnt_q     <= '0;
         rec_sel_q <= '0;
         rec_seg_q <= '0;
         mask_q    <= '0;
         pend_q    <= 16'hFFFF;
         pcol_q    <= 1'b0;
         perr_q    <= 1'b0;
         data_q    <= 16'hFFFF;
         fcol_q    <= 1'b0;
         ferr_q    <= 1'b0;
         fvld_q    <= 1'b0;
         ovr_q     <= 1'b0;
         selerr_q  <= 1'b0;
         to_q      <= '0;
         off_q     <= 1'b0;
      end else begin
         seg_m_q   <= segment;
         seg_s_q   <= seg_m_q;
         sel_m_q   <= digit_sel;
         sel_s_q   <= sel_m_q;
         col_m_q   <= colon;
         col_s_q   <= col_m_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rec_sel_q <= rec_sel_d;
         rec_seg_q <= rec_seg_d;
         mask_q    <= mask_d;
         pend_q    <= pend_d;
         pcol_q    <= pcol_d;
         perr_q    <= perr_d;
         data_q    <= data_d;
         fcol_q    <= fcol_d;
         ferr_q    <= ferr_d;
         fvld_q    <= fvld_d;
         ovr_q     <= ovr_d;
         selerr_q  <= selerr_d;
         to_q      <= to_d;
         off_q     <= off_d;
      end
   end

   assign frame_data  = data_q;
   assign frame_colon = fcol_q;
   assign frame_error = ferr_q;
   assign frame_valid = fvld_q;
   assign overrun     = ovr_q;
   assign sel_error   = selerr_q;
   assign display_off = off_q;

endmodule
